// File: rtl/gerador_pulso_pkg.sv
// Shared keypad definitions: event FSM state encoding and default timing constants.
package gerador_pulso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10,
        ST_LOCK    = 2'b11
    } state_e;

    localparam int unsigned HOLD_CYCLES_DEF   = 16;
    localparam int unsigned REPEAT_CYCLES_DEF = 8;
    localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/gerador_pulso.sv
// Key event generator: turns a debounced key level into press/release/auto-repeat
// pulses, a long-press level and a wrapping press counter.
module gerador_pulso
    import gerador_pulso_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             level_in,
    input  logic             enable,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] count_q;
    logic             press_q, release_q, repeat_q, held_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            count_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            // Disable overrides everything, including a pending release.
            if (!enable) begin
                state_q <= ST_LOCK;
                cnt_q   <= '0;
                held_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (level_in) begin
                            state_q <= ST_PRESSED;
                            press_q <= 1'b1;
                            count_q <= count_q + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!level_in) begin
                            state_q   <= ST_IDLE;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                            held_q    <= 1'b0;
                        end else if (cnt_q == HOLD_LAST) begin
                            state_q  <= ST_HELD;
                            cnt_q    <= '0;
                            held_q   <= 1'b1;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!level_in) begin
                            state_q   <= ST_IDLE;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                            held_q    <= 1'b0;
                        end else if (cnt_q == REPEAT_LAST) begin
                            cnt_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        // Only a released key may re-arm, so a held key can't fake a press.
                        cnt_q <= '0;
                        if (!level_in) state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_gerador_pulso.sv
// Bench for gerador_pulso: vector table plus scoreboarded multi-cycle sequences.
module tb_gerador_pulso;

    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       level_in = 1'b0;
    logic       enable = 1'b0;
    logic       press_pulse, release_pulse, repeat_pulse, held;
    logic [7:0] press_count;

    gerador_pulso #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst_n(rst_n), .level_in(level_in), .enable(enable),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .held(held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // {press, release, repeat, held, press_count}
    typedef struct {
        logic [11:0] v;
        int          ph;
    } exp_t;

    typedef struct {
        logic        lvl;
        logic        en;
        logic [11:0] v;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    int   exp_count = 0;
    vec_t tbl[16];

    function automatic logic [11:0] pk(input logic p, input logic r, input logic rp,
                                       input logic h, input int c);
        return {p, r, rp, h, 8'(c)};
    endfunction

    task automatic check(input logic [11:0] got, input logic [11:0] want, input int ph, input int idx);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL phase%0d item%0d: got p/r/rp/h=%b cnt=%0d, want p/r/rp/h=%b cnt=%0d",
                     ph, idx, got[11:8], got[7:0], want[11:8], want[7:0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({press_pulse, release_pulse, repeat_pulse, held, press_count}, e.v, e.ph, n_pop);
            n_pop++;
        end
    end

    task automatic drive(input logic lvl, input logic en, input logic [11:0] v, input int ph);
        exp_t e;
        @(negedge clk);
        level_in = lvl;
        enable   = en;
        e.v  = v;
        e.ph = ph;
        sb.push_back(e);
    endtask

    task automatic step(input logic lvl, input logic en, input logic p, input logic r,
                        input logic rp, input logic h, input int ph);
        if (p) exp_count++;
        drive(lvl, en, pk(p, r, rp, h, exp_count), ph);
    endtask

    // Key held for n sampling edges; expectations derived from the hold/repeat timeline.
    task automatic press_seq(input int n, input bit rel, input int ph);
        exp_count++;
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b1, pk(i == 0, 1'b0, (i >= HOLD) && ((i - HOLD) % REP == 0),
                                 i >= HOLD, exp_count), ph);
        if (rel) drive(1'b0, 1'b1, pk(1'b0, 1'b1, 1'b0, 1'b0, exp_count), ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        level_in = 1'b0;
        enable   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b1, pk(1, 0, 0, 0, 1)};
        tbl[2]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[3]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[4]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[5]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[6]  = '{1'b0, 1'b1, pk(0, 1, 0, 0, 1)};
        tbl[7]  = '{1'b0, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[8]  = '{1'b1, 1'b0, pk(0, 0, 0, 0, 1)};
        tbl[9]  = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[10] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 1)};
        tbl[11] = '{1'b1, 1'b1, pk(1, 0, 0, 0, 2)};
        tbl[12] = '{1'b1, 1'b0, pk(0, 0, 0, 0, 2)};
        tbl[13] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 2)};
        tbl[14] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 2)};
        tbl[15] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 2)};

        #1;
        check({press_pulse, release_pulse, repeat_pulse, held, press_count}, pk(0, 0, 0, 0, 0), 0, 0);
        do_reset();

        // Table: short press, disable in idle/pressed, lock re-arm
        for (int i = 0; i < 16; i++) drive(tbl[i].lvl, tbl[i].en, tbl[i].v, 1);
        exp_count = 2;

        // Long press with three repeats
        press_seq(40, 1'b1, 2);
        step(1'b0, 1'b1, 0, 0, 0, 0, 2);
        // Release on the hold threshold edge, and release just after it
        press_seq(16, 1'b1, 3);
        press_seq(17, 1'b1, 3);

        // Disable during long-press, re-enable with key still down
        press_seq(20, 1'b0, 4);
        step(1'b1, 1'b0, 0, 0, 0, 0, 4);
        step(1'b1, 1'b1, 0, 0, 0, 0, 4);
        step(1'b1, 1'b1, 0, 0, 0, 0, 4);
        step(1'b1, 1'b1, 0, 0, 0, 0, 4);
        step(1'b0, 1'b1, 0, 0, 0, 0, 4);
        step(1'b1, 1'b1, 1, 0, 0, 0, 4);
        step(1'b0, 1'b1, 0, 1, 0, 0, 4);

        // Counter wrap: 257 presses from reset
        do_reset();
        for (int i = 0; i < 257; i++) press_seq(1, 1'b1, 5);

        // Asynchronous reset mid long-press, then key still down
        press_seq(20, 1'b0, 6);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check({press_pulse, release_pulse, repeat_pulse, held, press_count}, pk(0, 0, 0, 0, 0), 6, 999);
        begin
            exp_t e;
            @(negedge clk);
            rst_n = 1'b1;
            exp_count = 1;
            e.v  = pk(1, 0, 0, 0, 1);
            e.ph = 7;
            sb.push_back(e);
        end
        step(1'b1, 1'b1, 0, 0, 0, 0, 7);
        step(1'b0, 1'b1, 0, 1, 0, 0, 7);

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
